// File: rtl/operand_fwd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fwd_ctrl_if
//  Purpose  : Bundles the ID-stage instruction fields, flush/clear controls
//             and the forwarding/stall outputs of operand_fwd_ctrl.
//  Ports    : id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
//             id_wr_en, id_is_load, flush, cnt_clr   (master -> slave)
//             stall, fwd_x_sel, fwd_y_sel, stall_cnt (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface operand_fwd_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_is_load;
  logic              flush;
  logic              cnt_clr;
  logic              stall;
  logic [1:0]        fwd_x_sel;
  logic [1:0]        fwd_y_sel;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wr_en, id_is_load, flush, cnt_clr,
    input  stall, fwd_x_sel, fwd_y_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wr_en, id_is_load, flush, cnt_clr,
    output stall, fwd_x_sel, fwd_y_sel, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/operand_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fwd_ctrl
//  Purpose  : Forwarding and load-use hazard controller for the four-stage
//             ID/EX/MEM/WB pipeline. Tracks destinations of in-flight
//             instructions and registers the EX operand mux selects.
//  Ports    : clk    - system clock (rising edge)
//             rst_n  - asynchronous active-low reset
//             bus    - operand_fwd_ctrl_if slave: ID fields, flush, cnt_clr
//                      in; stall (combinational), fwd_x_sel, fwd_y_sel,
//                      stall_cnt out
//  Select   : 00 regfile, 01 EX/MEM ALU, 10 MEM/WB, 11 WB write-back
//  Revision : 1.0  initial release
// ============================================================================
module operand_fwd_ctrl #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  operand_fwd_ctrl_if.slave     bus
);

  localparam logic [1:0]       c_SEL_RF  = 2'b00;
  localparam logic [1:0]       c_SEL_EX  = 2'b01;
  localparam logic [1:0]       c_SEL_MEM = 2'b10;
  localparam logic [1:0]       c_SEL_WB  = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  // Scoreboard records. Only the EX record needs the load flag: by the time
  // a load reaches MEM its data is forwardable like any other result.
  logic              r_ex_v,  r_mem_v,  r_wb_v;
  logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic              r_ex_wr, r_mem_wr, r_wb_wr;
  logic              r_ex_ld;

  logic [1:0]        r_fwd_x;
  logic [1:0]        r_fwd_y;
  logic [CNT_W-1:0]  r_cnt;

  logic w_x_ex, w_x_mem, w_x_wb;
  logic w_y_ex, w_y_mem, w_y_wb;
  logic w_stall;
  logic w_take;
  logic [1:0] w_sel_x, w_sel_y;

  // R0 is hardwired zero, so it never needs a forward.
  function automatic logic f_match(
    input logic              v,
    input logic              wr,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] src,
    input logic              use_src
  );
    return v && wr && use_src && (src != '0) && (rd == src);
  endfunction

  // Youngest producer wins. An EX match on a load never reaches here with
  // w_take set, because that case stalls instead.
  function automatic logic [1:0] f_sel(
    input logic m_ex,
    input logic m_mem,
    input logic m_wb,
    input logic ex_ld
  );
    if (m_ex && !ex_ld) return c_SEL_EX;
    else if (m_mem)     return c_SEL_MEM;
    else if (m_wb)      return c_SEL_WB;
    else                return c_SEL_RF;
  endfunction

  assign w_x_ex  = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  bus.id_rs1, bus.id_use_rs1);
  assign w_x_mem = f_match(r_mem_v, r_mem_wr, r_mem_rd, bus.id_rs1, bus.id_use_rs1);
  assign w_x_wb  = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  bus.id_rs1, bus.id_use_rs1);
  assign w_y_ex  = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  bus.id_rs2, bus.id_use_rs2);
  assign w_y_mem = f_match(r_mem_v, r_mem_wr, r_mem_rd, bus.id_rs2, bus.id_use_rs2);
  assign w_y_wb  = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  bus.id_rs2, bus.id_use_rs2);

  // Flush overrides a load-use hazard: the consumer is squashed anyway.
  assign w_stall = bus.id_valid && !bus.flush && r_ex_ld && (w_x_ex || w_y_ex);
  assign w_take  = bus.id_valid && !bus.flush && !w_stall;

  assign w_sel_x = w_take ? f_sel(w_x_ex, w_x_mem, w_x_wb, r_ex_ld) : c_SEL_RF;
  assign w_sel_y = w_take ? f_sel(w_y_ex, w_y_mem, w_y_wb, r_ex_ld) : c_SEL_RF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v   <= 1'b0;
      r_ex_rd  <= '0;
      r_ex_wr  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_mem_v  <= 1'b0;
      r_mem_rd <= '0;
      r_mem_wr <= 1'b0;
      r_wb_v   <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_wr  <= 1'b0;
      r_fwd_x  <= c_SEL_RF;
      r_fwd_y  <= c_SEL_RF;
      r_cnt    <= '0;
    end else begin
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_wb_wr  <= r_mem_wr;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
      r_mem_wr <= r_ex_wr;

      if (w_take) begin
        r_ex_v  <= 1'b1;
        r_ex_rd <= bus.id_rd;
        r_ex_wr <= bus.id_wr_en;
        r_ex_ld <= bus.id_is_load;
      end else begin
        r_ex_v  <= 1'b0;
        r_ex_rd <= '0;
        r_ex_wr <= 1'b0;
        r_ex_ld <= 1'b0;
      end

      r_fwd_x <= w_sel_x;
      r_fwd_y <= w_sel_y;

      if (bus.cnt_clr) begin
        r_cnt <= '0;
      end else if (w_stall && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.stall     = w_stall;
  assign bus.fwd_x_sel = r_fwd_x;
  assign bus.fwd_y_sel = r_fwd_y;
  assign bus.stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fwd_ctrl
//  Purpose  : Self-checking bench for operand_fwd_ctrl. Expected selects are
//             queued when an instruction is presented in ID and compared
//             once it reaches EX. The stall counter is narrowed to 8 bits so
//             saturation is reachable in a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_fwd_ctrl;

  localparam int         REG_AW = 3;
  localparam int         CNT_W  = 8;
  localparam logic [7:0] c_CMAX = 8'hFF;

  logic clk;
  logic rst_n;
  logic clr;

  typedef struct {
    string      tag;
    logic [1:0] x;
    logic [1:0] y;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  logic [7:0] exp_cnt;

  operand_fwd_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  operand_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one ID-stage instruction for one cycle. Must be entered before
  // the falling edge; returns 1 time unit after the next rising edge.
  task automatic step(
    input string      tag,
    input logic       v,
    input logic [2:0] rs1, input logic u1,
    input logic [2:0] rs2, input logic u2,
    input logic [2:0] rd,  input logic wr, input logic ld,
    input logic       fl,
    input logic       es,
    input logic [1:0] ex,  input logic [1:0] ey
  );
    exp_t e;
    bus.id_valid   = v;
    bus.id_rs1     = rs1;
    bus.id_use_rs1 = u1;
    bus.id_rs2     = rs2;
    bus.id_use_rs2 = u2;
    bus.id_rd      = rd;
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.flush      = fl;
    bus.cnt_clr    = clr;
    @(negedge clk);
    checks++;
    if (bus.stall !== es) begin
      errors++;
      $display("FAIL %s stall got %b exp %b", tag, bus.stall, es);
    end
    e.tag = tag;
    e.x   = ex;
    e.y   = ey;
    sb.push_back(e);
    if (clr) exp_cnt = 8'd0;
    else if (es && exp_cnt != c_CMAX) exp_cnt = exp_cnt + 8'd1;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (bus.fwd_x_sel !== e.x) begin
      errors++;
      $display("FAIL %s fwd_x_sel got %b exp %b", e.tag, bus.fwd_x_sel, e.x);
    end
    checks++;
    if (bus.fwd_y_sel !== e.y) begin
      errors++;
      $display("FAIL %s fwd_y_sel got %b exp %b", e.tag, bus.fwd_y_sel, e.y);
    end
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d exp %0d", e.tag, bus.stall_cnt, exp_cnt);
    end
  endtask

  task automatic nop();
    step("nop", 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.fwd_x_sel !== 2'b00 || bus.fwd_y_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel got %b/%b exp 00/00", bus.fwd_x_sel, bus.fwd_y_sel);
    end
    checks++;
    if (bus.stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d exp 0", bus.stall_cnt);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b exp 0", bus.stall);
    end
    #20;
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_alu_chain();
    drain();
    step("add_r3", 1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0, 2'b00, 2'b00);
    step("sub_r3", 1, 3'd3, 1, 3'd1, 1, 3'd4, 1, 0, 0, 0, 2'b01, 2'b00);
  endtask

  task automatic test_distance();
    drain();
    step("wr_r5_a", 1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    step("indep_a", 1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0, 0, 0, 2'b00, 2'b00);
    step("dist2",   1, 3'd0, 0, 3'd5, 1, 3'd7, 1, 0, 0, 0, 2'b00, 2'b10);
    drain();
    step("wr_r5_b", 1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    step("indep_b", 1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0, 0, 0, 2'b00, 2'b00);
    step("indep_c", 1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 0, 0, 0, 2'b00, 2'b00);
    step("dist3",   1, 3'd0, 0, 3'd5, 1, 3'd1, 1, 0, 0, 0, 2'b00, 2'b11);
  endtask

  task automatic test_load_use();
    drain();
    step("ld_r2",     1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0, 2'b00, 2'b00);
    step("lu_stall",  1, 3'd2, 1, 3'd0, 0, 3'd3, 1, 0, 0, 1, 2'b00, 2'b00);
    step("lu_retry",  1, 3'd2, 1, 3'd0, 0, 3'd3, 1, 0, 0, 0, 2'b10, 2'b00);
    // Load feeding rs2 must stall as well.
    drain();
    step("ld_r6",     1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1, 0, 0, 2'b00, 2'b00);
    step("lu_stall2", 1, 3'd0, 0, 3'd6, 1, 3'd1, 1, 0, 0, 1, 2'b00, 2'b00);
    step("lu_retry2", 1, 3'd0, 0, 3'd6, 1, 3'd1, 1, 0, 0, 0, 2'b00, 2'b10);
  endtask

  task automatic test_priority_r0();
    drain();
    step("wr_r4_old", 1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00);
    step("wr_r4_new", 1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00);
    step("prio_r4",   1, 3'd4, 1, 3'd4, 0, 3'd1, 1, 0, 0, 0, 2'b01, 2'b00);
    drain();
    step("ld_r0",     1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0, 0, 2'b00, 2'b00);
    step("rd_r0",     1, 3'd0, 1, 3'd0, 1, 3'd1, 1, 0, 0, 0, 2'b00, 2'b00);
    step("rd_r0_mem", 1, 3'd0, 1, 3'd0, 1, 3'd2, 1, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic test_flush();
    drain();
    step("ld_r2_f",  1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0, 2'b00, 2'b00);
    step("flush_lu", 1, 3'd2, 1, 3'd2, 1, 3'd3, 1, 0, 1, 0, 2'b00, 2'b00);
    // The squashed consumer must not become a forwarding source for R3.
    step("after_fl", 1, 3'd3, 1, 3'd0, 0, 3'd1, 1, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic test_midreset();
    drain();
    step("wr_r3_pre", 1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0, 0, 2'b00, 2'b00);
    step("wr_r5_pre", 1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    step("use_r5_pre", 1, 3'd5, 1, 3'd3, 1, 3'd6, 1, 0, 0, 0, 2'b01, 2'b10);
    // A consumer of R6 in ID would normally forward from EX; reset now.
    bus.id_valid   = 1'b1;
    bus.id_rs1     = 3'd6;
    bus.id_use_rs1 = 1'b1;
    bus.id_rs2     = 3'd0;
    bus.id_use_rs2 = 1'b0;
    bus.id_is_load = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.fwd_x_sel !== 2'b00 || bus.fwd_y_sel !== 2'b00) begin
      errors++;
      $display("FAIL midreset_sel got %b/%b exp 00/00", bus.fwd_x_sel, bus.fwd_y_sel);
    end
    checks++;
    if (bus.stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset_cnt got %0d exp 0", bus.stall_cnt);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stall got %b exp 0", bus.stall);
    end
    exp_cnt = 8'd0;
    bus.id_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step("post_r6", 1, 3'd6, 1, 3'd5, 1, 3'd1, 1, 0, 0, 0, 2'b00, 2'b00);
    step("post_r3", 1, 3'd3, 1, 3'd6, 1, 3'd2, 1, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic test_cnt_sat();
    drain();
    while (exp_cnt < 8'd254) begin
      step("sat_ld", 1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0, 0, 2'b00, 2'b00);
      step("sat_st", 1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0, 1, 2'b00, 2'b00);
    end
    repeat (3) begin
      step("sat_ld_x", 1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0, 0, 2'b00, 2'b00);
      step("sat_top",  1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0, 1, 2'b00, 2'b00);
    end
    checks++;
    if (bus.stall_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL sat_hold stall_cnt got %0d exp 255", bus.stall_cnt);
    end
  endtask

  task automatic test_cnt_clr();
    step("clr_ld",   1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0, 0, 2'b00, 2'b00);
    clr = 1'b1;
    step("clr_st",   1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0, 1, 2'b00, 2'b00);
    clr = 1'b0;
    step("clr_ld2",  1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0, 0, 2'b00, 2'b00);
    step("clr_st2",  1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0, 1, 2'b00, 2'b00);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    exp_cnt        = 8'd0;
    clr            = 1'b0;
    rst_n          = 1'b0;
    bus.id_valid   = 1'b0;
    bus.id_rs1     = '0;
    bus.id_rs2     = '0;
    bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0;
    bus.id_rd      = '0;
    bus.id_wr_en   = 1'b0;
    bus.id_is_load = 1'b0;
    bus.flush      = 1'b0;
    bus.cnt_clr    = 1'b0;

    test_reset();
    test_alu_chain();
    test_distance();
    test_load_use();
    test_priority_r0();
    test_flush();
    test_midreset();
    test_cnt_sat();
    test_cnt_clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_fwd_ctrl.md
# operand_fwd_ctrl

Forwarding and load-use hazard controller for the 16-bit four-stage pipeline (ID, EX, MEM, WB). It tracks the destination register of every in-flight instruction and produces the registered select codes for the ALU X and Y operand multiplexers. It also asserts a one-cycle pipeline stall when a load result is needed by the very next instruction. It sits beside the ID/EX pipeline register, and its select outputs drive the operand muxes in EX.

## Interface
Parameters:
- REG_AW, 3, register-address width (8 architectural registers, R0 hardwired zero)
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_AW  X operand source register
- id_rs2  in  REG_AW  Y operand source register
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_AW  destination register
- id_wr_en  in  1  instruction writes rd
- id_is_load  in  1  instruction is a memory load
- flush  in  1  squash the instruction leaving ID (branch taken)
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall  out  1  combinational; freeze PC and IF/ID, insert bubble into EX
- fwd_x_sel  out  2  registered X-mux select for the instruction now in EX
- fwd_y_sel  out  2  registered Y-mux select for the instruction now in EX
- stall_cnt  out  CNT_W  count of stall cycles, saturating

Select encoding:
- 00: register file
- 01: EX/MEM ALU result
- 10: MEM/WB result
- 11: WB write-back data

## Operation
- Internal scoreboard holds three records, ex_r, mem_r and wb_r.
  - Each record is {v, rd, wr, ld}.
  - Every clock: wb_r<=mem_r and mem_r<=ex_r.
  - ex_r<=ID fields when id_valid && !stall && !flush; otherwise ex_r<=bubble (v=0).
- Match rule: source s matches record r when r.v && r.wr && r.rd==s && s!=0 && the use flag is set. R0 never matches.
- Load-use stall: stall = id_valid && !flush && (rs1 or rs2 matches ex_r) && ex_r.ld.
- Select computation at ID, registered into fwd_*_sel on the clock edge:
  - Priority, youngest first: ex_r match with !ex_r.ld -> 01.
  - Else mem_r match -> 10.
  - Else wb_r match -> 11.
  - Else 00.
- When stall or flush is asserted, or id_valid=0, fwd_x_sel and fwd_y_sel load 00.
- After a stall, the load has moved into mem_r. The retried consumer therefore gets 10.
- stall_cnt:
  - Increments on every cycle with stall=1 and saturates at all-ones.
  - cnt_clr has priority over increment.
- flush and stall in the same cycle: flush wins, so stall is forced to 0 and a bubble enters EX.

## Timing
- Reset (rst_n=0, asynchronous): all records v=0, fwd_x_sel=00, fwd_y_sel=00, stall_cnt=0. stall is 0 because ex_r.v=0.
- Outputs valid from the first rising edge after rst_n deasserts. Reset mid-stream discards all in-flight records.
- stall has zero latency: it is combinational from the ID inputs and ex_r. The pipeline must sample it the same cycle.
- Select latency is one cycle. The value computed in ID is presented during EX of the same instruction.
- A load stall always lasts exactly 1 cycle, with no back-to-back stalls for the same consumer.
- stall_cnt updates one cycle after the stall cycle.

## Test plan
- ALU-to-ALU chain:
  - Stimulus: ID sends ADD R3 (wr), then SUB with rs1=R3 (use_rs1=1).
  - Response: during SUB in EX, fwd_x_sel=01, fwd_y_sel=00, stall=0.
- Distance-2 and distance-3 forwarding:
  - Stimulus: write R5, insert one independent instruction, then read R5 on rs2. Repeat with two independent instructions.
  - Response: fwd_y_sel=10, then fwd_y_sel=11.
- Load-use:
  - Stimulus: LD R2, then ADD with rs1=R2.
  - Response: stall=1 for exactly 1 cycle and stall_cnt goes 0->1. The following cycle has stall=0, and the ADD reaches EX with fwd_x_sel=10.
- Priority and R0:
  - Stimulus: R4 is written in both MEM and EX; the consumer reads R4 on rs1.
  - Response: fwd_x_sel=01.
  - Stimulus: any producer with rd=R0.
  - Response: select stays 00.
- Flush and reset:
  - Stimulus: flush asserted together with a load-use condition.
  - Response: stall=0 and the next EX selects are 00.
  - Stimulus: rst_n pulsed low mid-sequence.
  - Response: all selects and stall_cnt read 0 immediately, with no forwarding from pre-reset writers.
- Counter saturation:
  - Stimulus: preload stall_cnt to 0xFFFE by repeated stalls, then force 3 more stalls.
  - Response: stall_cnt holds 0xFFFF.
  - Stimulus: cnt_clr together with a stall.
  - Response: stall_cnt=0.
